lighthouse_sync_decoder: RTL and testbench

LIGHTHOUSE_SYNC_DECODER -- requirements
Module: lighthouse_sync_decoder

---
 rtl/lighthouse_sync_decoder.sv | 170 +++++++++++++++++
 tb/tb_lighthouse_sync_decoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lighthouse_sync_decoder.sv
// Lighthouse sync-pulse decoder.
// Measures each photodiode pulse and turns sync pulses into axis/skip/data bits.
// It also tells the two base stations apart by the spacing between their rising edges.
// The data bit of the selected station is forwarded to the OOTX receiver as DATA_OUT/DCLK.
//
// state    | meaning
// DC_IDLE  | no bit clock pending, DCLK low
// DC_SETUP | DATA_OUT updated this cycle, DCLK rises next cycle
// DC_HIGH1 | first DCLK high cycle
// DC_HIGH2 | second DCLK high cycle
module lighthouse_sync_decoder #(
   parameter int MIN_SYNC  = 800,
   parameter int MAX_SYNC  = 2300,
   parameter int BASE      = 917,
   parameter int STEP      = 167,
   parameter int GROUP_GAP = 8000,
   parameter int STATION   = 0
) (
   input  logic CLK,
   input  logic RESET,
   input  logic SENSOR,
   output logic DATA_OUT,
   output logic DCLK,
   output logic AXIS,
   output logic SKIP,
   output logic STATION_ID,
   output logic VALID,
   output logic ERROR
);

   typedef enum logic [1:0] {
      DC_IDLE  = 2'd0,
      DC_SETUP = 2'd1,
      DC_HIGH1 = 2'd2,
      DC_HIGH2 = 2'd3
   } dclk_state_t;

   localparam logic STATION_BIT = (STATION != 0);

   logic        s_meta;
   logic        s_sync;
   logic        s_prev;
   logic [1:0]  settle;
   logic        armed;
   logic [11:0] width;
   logic [15:0] gap_cnt;
   logic [15:0] rise_gap;
   logic        have_prev;
   logic        last_idx;

   logic        rise;
   logic        fall;
   logic        too_narrow;
   logic        too_wide;
   logic        is_valid;
   logic        is_error;
   logic        idx;
   logic        fire;
   logic [2:0]  code;

   dclk_state_t state;
   dclk_state_t state_next;
   logic        dclk_next;

   assign rise       = s_sync & ~s_prev;
   // armed is only set after S has been seen low, so a pulse straddling reset never classifies
   assign fall       = ~s_sync & s_prev & armed;
   assign too_narrow = int'(width) < MIN_SYNC;
   assign too_wide   = int'(width) > MAX_SYNC;
   assign is_valid   = fall & ~too_narrow & ~too_wide;
   assign is_error   = fall & too_wide;
   assign idx        = have_prev & ~last_idx & (int'(rise_gap) < GROUP_GAP);
   assign fire       = is_valid & (idx == STATION_BIT);

   // Width code: how many of the seven thresholds BASE+STEP*k the pulse reaches
   always_comb begin
      code = 3'd0;
      for (int k = 1; k <= 7; k++) begin
         if (int'(width) >= BASE + STEP * k) code = code + 3'd1;
      end
   end

   // Synchronizer, edge history and arming after reset
   always_ff @(posedge CLK) begin
      if (RESET) begin
         s_meta <= 1'b0;
         s_sync <= 1'b0;
         s_prev <= 1'b0;
         settle <= 2'd0;
         armed  <= 1'b0;
      end else begin
         s_meta <= SENSOR;
         s_sync <= s_meta;
         s_prev <= s_sync;
         if (settle != 2'd2) settle <= settle + 2'd1;
         // the first two cycles after reset still carry the cleared synchronizer, not the sensor
         if (settle == 2'd2 && !s_sync) armed <= 1'b1;
      end
   end

   // Pulse width and rising-edge spacing counters
   always_ff @(posedge CLK) begin
      if (RESET) begin
         width    <= 12'd0;
         gap_cnt  <= 16'd0;
         rise_gap <= 16'd0;
      end else begin
         if (s_sync) begin
            if (!s_prev)                width <= 12'd1;
            else if (width != 12'hFFF)  width <= width + 12'd1;
         end
         // gap_cnt counts cycles since the rising edge of the last valid pulse;
         // at the falling edge that rising edge lies width cycles back
         if (is_valid)                 gap_cnt <= {4'd0, width} + 16'd1;
         else if (gap_cnt != 16'hFFFF) gap_cnt <= gap_cnt + 16'd1;
         if (rise) rise_gap <= gap_cnt;
      end
   end

   // Classification outputs and station history
   always_ff @(posedge CLK) begin
      if (RESET) begin
         VALID      <= 1'b0;
         ERROR      <= 1'b0;
         AXIS       <= 1'b0;
         SKIP       <= 1'b0;
         STATION_ID <= 1'b0;
         DATA_OUT   <= 1'b0;
         have_prev  <= 1'b0;
         last_idx   <= 1'b0;
      end else begin
         VALID <= is_valid;
         ERROR <= is_error;
         if (is_valid) begin
            AXIS       <= code[0];
            SKIP       <= code[2];
            STATION_ID <= idx;
            have_prev  <= 1'b1;
            last_idx   <= idx;
         end
         if (fire) DATA_OUT <= code[1];
      end
   end

   // Bit-clock sequencer state register
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= DC_IDLE;
         DCLK  <= 1'b0;
      end else begin
         state <= state_next;
         DCLK  <= dclk_next;
      end
   end

   // Bit-clock next state: one setup cycle, then two high cycles
   always_comb begin
      state_next = state;
      dclk_next  = 1'b0;
      case (state)
         DC_IDLE:  if (fire) state_next = DC_SETUP;
         DC_SETUP: state_next = DC_HIGH1;
         DC_HIGH1: state_next = DC_HIGH2;
         DC_HIGH2: state_next = DC_IDLE;
         default:  state_next = DC_IDLE;
      endcase
      dclk_next = (state_next == DC_HIGH1) || (state_next == DC_HIGH2);
   end

endmodule

// File: tb/tb_lighthouse_sync_decoder.sv
// Testbench for lighthouse_sync_decoder: stimulus pushes expectations, a monitor pops and compares.
module tb_lighthouse_sync_decoder;

   localparam int MIN_SYNC  = 800;
   localparam int MAX_SYNC  = 2300;
   localparam int BASE      = 917;
   localparam int STEP      = 167;
   localparam int GROUP_GAP = 8000;
   localparam int STATION   = 0;

   logic CLK = 1'b0;
   logic RESET = 1'b1;
   logic SENSOR = 1'b1;
   logic DATA_OUT, DCLK, AXIS, SKIP, STATION_ID, VALID, ERROR;

   lighthouse_sync_decoder #(
      .MIN_SYNC(MIN_SYNC), .MAX_SYNC(MAX_SYNC), .BASE(BASE), .STEP(STEP),
      .GROUP_GAP(GROUP_GAP), .STATION(STATION)
   ) dut (
      .CLK(CLK), .RESET(RESET), .SENSOR(SENSOR),
      .DATA_OUT(DATA_OUT), .DCLK(DCLK), .AXIS(AXIS), .SKIP(SKIP),
      .STATION_ID(STATION_ID), .VALID(VALID), .ERROR(ERROR)
   );

   always #31 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      bit is_err;
      int cyc;
      bit axis;
      bit skip;
      bit sid;
   } ev_t;

   typedef struct {
      int cyc;
      bit data;
   } bit_t;

   ev_t  exp_q[$];
   bit_t dq[$];
   bit   rx_bits[$];

   int n_checks = 0;
   int n_pass   = 0;

   bit have_prev = 0;
   bit last_idx  = 0;
   int last_rise = 0;

   function automatic void check(string name, int act, int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endfunction

   // Reference model: pulse width and rising-edge time in, expected strobes out
   function automatic void model(int w, int rise, int fall);
      ev_t  e;
      bit_t b;
      int   code;
      bit   idx;
      if (w < MIN_SYNC) return;
      e.cyc  = fall + 3;
      e.axis = 0;
      e.skip = 0;
      e.sid  = 0;
      if (w > MAX_SYNC) begin
         e.is_err = 1;
         exp_q.push_back(e);
         return;
      end
      code = 0;
      for (int k = 1; k <= 7; k++) if (w >= BASE + STEP * k) code++;
      idx = have_prev && !last_idx && (rise - last_rise < GROUP_GAP);
      e.is_err = 0;
      e.axis   = (code % 2) == 1;
      e.skip   = code >= 4;
      e.sid    = idx;
      exp_q.push_back(e);
      have_prev = 1;
      last_idx  = idx;
      last_rise = rise;
      if (idx == (STATION != 0)) begin
         b.cyc  = fall + 4;
         b.data = ((code / 2) % 2) == 1;
         dq.push_back(b);
      end
   endfunction

   // One sensor pulse of 'width' cycles; next pulse may rise 'period' cycles after this rise
   task automatic pulse(input int width, input int period, input bit expect_it);
      int rise, fall;
      @(posedge CLK); #1;
      SENSOR = 1'b1;
      rise = cyc;
      repeat (width) @(posedge CLK);
      #1;
      SENSOR = 1'b0;
      fall = cyc;
      if (expect_it) model(width, rise, fall);
      repeat (period - width - 1) @(posedge CLK);
   endtask

   task automatic do_reset();
      @(posedge CLK); #1;
      RESET = 1'b1;
      have_prev = 0;
      repeat (3) @(posedge CLK);
      #1;
      RESET = 1'b0;
      repeat (6) @(posedge CLK);
   endtask

   // Monitor: compares every strobe and every DCLK rising edge against the queues
   initial begin
      ev_t  e;
      bit_t b;
      bit   dclk_prev = 0;
      int   dlen = 0;
      forever begin
         @(negedge CLK);
         if (VALID || ERROR) begin
            if (exp_q.size() == 0) begin
               check("strobe_unexpected", int'({VALID, ERROR}), 0);
            end else begin
               e = exp_q.pop_front();
               check("strobe_cycle", cyc, e.cyc);
               check("valid", int'(VALID), int'(!e.is_err));
               check("error", int'(ERROR), int'(e.is_err));
               if (!e.is_err) begin
                  check("axis", int'(AXIS), int'(e.axis));
                  check("skip", int'(SKIP), int'(e.skip));
                  check("station_id", int'(STATION_ID), int'(e.sid));
               end
            end
         end
         if (DCLK && !dclk_prev) begin
            rx_bits.push_back(DATA_OUT);
            if (dq.size() == 0) begin
               check("dclk_unexpected", 1, 0);
            end else begin
               b = dq.pop_front();
               check("dclk_cycle", cyc, b.cyc);
               check("data_out", int'(DATA_OUT), int'(b.data));
            end
         end
         if (DCLK) dlen++;
         else if (dlen != 0) begin
            check("dclk_high_len", dlen, 2);
            dlen = 0;
         end
         dclk_prev = DCLK;
      end
   end

   bit          stream[35];
   logic [15:0] word;

   initial begin
      int w, fw;

      // reset state, then a pulse already high at reset release must be discarded
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst_data_out", int'(DATA_OUT), 0);
      check("rst_dclk", int'(DCLK), 0);
      check("rst_axis", int'(AXIS), 0);
      check("rst_skip", int'(SKIP), 0);
      check("rst_station_id", int'(STATION_ID), 0);
      check("rst_valid", int'(VALID), 0);
      check("rst_error", int'(ERROR), 0);
      @(posedge CLK); #1;
      RESET = 1'b0;
      repeat (1000) @(posedge CLK);
      #1;
      SENSOR = 1'b0;
      repeat (10) @(posedge CLK);

      // OOTX bit stream: 17 zeros, a one, then 0xABCD MSB-first followed by its sync bit
      word = 16'hABCD;
      for (int i = 0; i < 17; i++) stream[i] = 1'b0;
      stream[17] = 1'b1;
      for (int i = 0; i < 16; i++) stream[18 + i] = word[15 - i];
      stream[34] = 1'b1;
      rx_bits.delete();
      for (int i = 0; i < 35; i++) begin
         case (i)
            0:       w = 1000;
            1:       w = 800;
            2:       w = 1083;
            3:       w = 1084;
            17:      w = 1500;
            18:      w = 2167;
            20:      w = 2300;
            default: w = stream[i] ? int'($urandom_range(1251, 1300)) : int'($urandom_range(800, 840));
         endcase
         pulse(w, w + int'($urandom_range(4, 12)), 1'b1);
         if (i == 2) begin
            pulse(799, 799 + 8, 1'b1);
            pulse(2301, 2301 + 8, 1'b1);
         end
         fw = (i == 4) ? 2300 : int'($urandom_range(800, 840));
         pulse(fw, fw + int'($urandom_range(4, 12)), 1'b1);
      end
      repeat (10) @(posedge CLK);
      check("ootx_bit_count", rx_bits.size(), 35);
      for (int i = 0; i < 35 && i < rx_bits.size(); i++)
         check($sformatf("ootx_bit_%0d", i), int'(rx_bits[i]), int'(stream[i]));

      // reset in the middle of a pulse aborts it
      @(posedge CLK); #1;
      SENSOR = 1'b1;
      repeat (600) @(posedge CLK);
      #1;
      RESET = 1'b1;
      have_prev = 0;
      repeat (3) @(posedge CLK);
      #1;
      RESET = 1'b0;
      repeat (600) @(posedge CLK);
      #1;
      SENSOR = 1'b0;
      repeat (10) @(posedge CLK);

      // station pairing: 6400 apart pairs up, 9000 apart does not
      do_reset();
      pulse(1333, 6400, 1'b1);
      pulse(1167, 1167 + 10, 1'b1);
      pulse(1333, 9000, 1'b1);
      pulse(1167, 1167 + 10, 1'b1);

      repeat (20) @(posedge CLK);
      check("pending_strobes", exp_q.size(), 0);
      check("pending_dclk", dq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
